// File: rtl/regfile_mp_if.sv
// regfile_mp_if: access bus for the multi-read-port register file.
// Carries the flush request, one write port and NRD packed read ports.
// Ports: master drives flush/waddr/wreq/wdata/raddr/rreq and sees ready/rdata/rvalid;
//        slave is the register file side of the same signals.
interface regfile_mp_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4,
  parameter int NRD    = 2
);
  logic                     flush;
  logic                     ready;
  logic [AWIDTH-1:0]        waddr;
  logic                     wreq;
  logic [DWIDTH-1:0]        wdata;
  logic [NRD*AWIDTH-1:0]    raddr;
  logic [NRD-1:0]           rreq;
  logic [NRD*DWIDTH-1:0]    rdata;
  logic [NRD-1:0]           rvalid;

  modport master (
    output flush, waddr, wreq, wdata, raddr, rreq,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  flush, waddr, wreq, wdata, raddr, rreq,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2**AWIDTH x DWIDTH register file, one write port, NRD read ports, zero-scrub on clear/flush.
// Latency: reads return registered data one cycle after rreq; writes land at the same edge.
// Backpressure: ready=0 while scrubbing; wreq/rreq presented then are dropped, not queued.
//
// Ports:
//   clk    - single rising-edge clock
//   clear  - synchronous active-high reset; starts a scrub from entry 0
//   bus    - regfile_mp_if.slave: flush, waddr/wreq/wdata, raddr/rreq (packed per port),
//            ready, rdata/rvalid (packed per port, port k at [k*W +: W])
// Parameters must match those of the connected regfile_mp_if instance.
// Build option: define REGFILE_R0_ZERO_EN to hardwire entry 0 to zero.
module regfile_mp #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4,
  parameter int NRD    = 2
) (
  input  logic         clk,
  input  logic         clear,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic {
    SCRUB = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [AWIDTH-1:0]      scrub_cnt;
  logic [AWIDTH-1:0]      scrub_cnt_nxt;

  // Storage has no reset so it can map onto a RAM; the scrub zeroes it.
  logic [DWIDTH-1:0]      mem [DEPTH];

  logic                   mem_we;
  logic [AWIDTH-1:0]      mem_wa;
  logic [DWIDTH-1:0]      mem_wd;

  logic                   access_ok;
  logic                   wr_drop;
  logic [NRD-1:0]         rd_fire;
  logic [NRD*DWIDTH-1:0]  rd_all;

  logic [NRD*DWIDTH-1:0]  rdata_q;
  logic [NRD-1:0]         rvalid_q;

  assign bus.ready  = (state == IDLE);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

`ifdef REGFILE_R0_ZERO_EN
  assign wr_drop = (bus.waddr == '0);
`else
  assign wr_drop = 1'b0;
`endif

  // Next state, scrub counter and the single array write port.
  // clear outranks flush, which outranks normal access.
  always_comb begin
    state_nxt     = state;
    scrub_cnt_nxt = scrub_cnt;
    mem_we        = 1'b0;
    mem_wa        = bus.waddr;
    mem_wd        = bus.wdata;
    access_ok     = 1'b0;

    case (state)
      SCRUB: begin
        // flush is deliberately ignored here: a scrub in progress is never extended.
        mem_we        = 1'b1;
        mem_wa        = scrub_cnt;
        mem_wd        = '0;
        scrub_cnt_nxt = scrub_cnt + 1'b1;
        if (&scrub_cnt) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (bus.flush) begin
          // Any write/read offered with the flush is dropped.
          state_nxt     = SCRUB;
          scrub_cnt_nxt = '0;
        end else begin
          access_ok = 1'b1;
          mem_we    = bus.wreq && !wr_drop;
        end
      end
      default: begin
        state_nxt     = SCRUB;
        scrub_cnt_nxt = '0;
      end
    endcase

    // The array is left untouched on the clear edge itself.
    if (clear) begin
      mem_we    = 1'b0;
      access_ok = 1'b0;
    end
  end

  // Per-port read mux with same-cycle write bypass.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AWIDTH-1:0] ra;
    logic [DWIDTH-1:0] rd_val;

    assign ra = bus.raddr[k*AWIDTH +: AWIDTH];

    always_comb begin
      rd_val = mem[ra];
      if (bus.wreq && (bus.waddr == ra)) begin
        rd_val = bus.wdata;
      end
`ifdef REGFILE_R0_ZERO_EN
      // Entry 0 reads as zero even when it is the bypass target.
      if (ra == '0) begin
        rd_val = '0;
      end
`endif
    end

    assign rd_all[k*DWIDTH +: DWIDTH] = rd_val;
    assign rd_fire[k]                 = access_ok && bus.rreq[k];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= SCRUB;
      scrub_cnt <= '0;
      rdata_q   <= '0;
      rvalid_q  <= '0;
    end else begin
      state     <= state_nxt;
      scrub_cnt <= scrub_cnt_nxt;
      rvalid_q  <= rd_fire;
      for (int k = 0; k < NRD; k++) begin
        if (rd_fire[k]) begin
          rdata_q[k*DWIDTH +: DWIDTH] <= rd_all[k*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // A clear always lands in a fresh scrub with no read response.
  a_clear_restarts : assert property (@(posedge clk)
    clear |=> (state == SCRUB) && (scrub_cnt == '0) && (rvalid_q == '0));

  // No read response ever follows a scrub cycle.
  a_no_rvalid_after_scrub : assert property (@(posedge clk)
    (!clear && state == SCRUB) |=> (rvalid_q == '0));

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
// tb_regfile_mp: randomized + directed bench for regfile_mp with a scoreboard.
// A posedge reference model pushes expected read data per port; a negedge monitor
// pops on rvalid and checks ready, rvalid and held rdata every cycle.
module tb_regfile_mp;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NRD   = 2;
  localparam int DEPTH = 16;

`ifdef REGFILE_R0_ZERO_EN
  localparam logic [15:0] R0_EXP = 16'h0000;
`else
  localparam logic [15:0] R0_EXP = 16'h9999;
`endif

  logic clk = 1'b0;
  logic clear;

  always #5 clk = ~clk;

  regfile_mp_if #(.DWIDTH(DW), .AWIDTH(AW), .NRD(NRD)) bus ();

  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NRD(NRD)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Observable behaviour only: a scrub makes the bank all-zero and unavailable for
  // DEPTH cycles; while available, reads see the array (or same-cycle write data).
  bit          model_on = 1'b0;
  int          scrub_left = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] hold_exp [NRD];
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  function automatic logic [15:0] expect_read(input logic [3:0] a);
`ifdef REGFILE_R0_ZERO_EN
    if (a == 4'd0) return 16'h0000;
`endif
    if (bus.wreq && bus.waddr == a) return bus.wdata;
    return ref_mem[a];
  endfunction

  always @(posedge clk) begin
    if (clear === 1'b1) begin
      model_on   = 1'b1;
      scrub_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
      for (int k = 0; k < NRD; k++) hold_exp[k] = 16'h0;
    end else if (model_on) begin
      if (scrub_left > 0) begin
        scrub_left = scrub_left - 1;
      end else if (bus.flush) begin
        scrub_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
      end else begin
        for (int k = 0; k < NRD; k++) begin
          if (bus.rreq[k]) begin
            logic [15:0] d;
            d = expect_read(bus.raddr[k*AW +: AW]);
            if (k == 0) q0.push_back(d); else q1.push_back(d);
            hold_exp[k] = d;
          end
        end
        if (bus.wreq) begin
`ifdef REGFILE_R0_ZERO_EN
          if (bus.waddr != 4'd0) ref_mem[bus.waddr] = bus.wdata;
`else
          ref_mem[bus.waddr] = bus.wdata;
`endif
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (model_on) begin
      check("ready", {31'b0, bus.ready}, {31'b0, scrub_left == 0});
      for (int k = 0; k < NRD; k++) begin
        logic        exp_v;
        logic [15:0] e;
        logic [15:0] act;
        exp_v = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
        act   = bus.rdata[k*DW +: DW];
        check($sformatf("rvalid%0d", k), {31'b0, bus.rvalid[k]}, {31'b0, exp_v});
        if (exp_v) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("rdata%0d", k), {16'b0, act}, {16'b0, e});
        end else begin
          check($sformatf("rdata%0d_hold", k), {16'b0, act}, {16'b0, hold_exp[k]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fl, input bit wr, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] rr, input logic [3:0] ra0, input logic [3:0] ra1);
    bus.flush = fl;
    bus.wreq  = wr;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.rreq  = rr;
    bus.raddr = {ra1, ra0};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
  endtask

  // Counts cycles until ready rises; gives up after 64.
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a += 2) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 4'(a), 4'(a + 1));
      step();
    end
    idle();
    step();
  endtask

  initial begin
    int n;
    clear = 1'b1;
    idle();
    step();
    step();
    clear = 1'b0;

    // Reset scrub length, then every entry reads zero.
    wait_ready(n);
    check("scrub_len_reset", n, 16);
    read_all();

    // Write then read with latency 1; port 1 idle.
    drive(1'b0, 1'b1, 4'd5, 16'hBEEF, 2'b00, 4'd0, 4'd0);
    step();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b01, 4'd5, 4'd0);
    step();
    check("read_beef", {16'b0, bus.rdata[15:0]}, 32'hBEEF);
    idle();
    step();

    // Bypass on port 0, array read on port 1; then both ports on one address.
    drive(1'b0, 1'b1, 4'd4, 16'hAAAA, 2'b00, 4'd0, 4'd0);
    step();
    drive(1'b0, 1'b1, 4'd3, 16'h1234, 2'b11, 4'd3, 4'd4);
    step();
    check("bypass_p0", {16'b0, bus.rdata[15:0]}, 32'h1234);
    check("bypass_p1", {16'b0, bus.rdata[31:16]}, 32'hAAAA);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 4'd5, 4'd5);
    step();
    idle();
    step();

    // Fill with FFFF, then flush colliding with a write and reads.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b1, 4'(a), 16'hFFFF, 2'b00, 4'd0, 4'd0);
      step();
    end
    drive(1'b1, 1'b1, 4'd7, 16'h5555, 2'b11, 4'd7, 4'd7);
    step();
    n = 0;
    while (bus.ready !== 1'b1 && n < 64) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
      n++;
    end
    idle();
    check("scrub_len_flush", n, 16);
    read_all();

    // clear at scrub cycle 8 restarts the full scrub.
    drive(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    step();
    idle();
    for (int i = 0; i < 7; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_ready(n);
    check("scrub_len_midclear", n, 16);

    // A second flush at scrub cycle 10 does not extend it.
    drive(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    step();
    idle();
    for (int i = 0; i < 9; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    wait_ready(n);
    check("scrub_len_reflush", n + 10, 16);

    // Entry 0 write with simultaneous read.
    drive(1'b0, 1'b1, 4'd0, 16'h9999, 2'b01, 4'd0, 4'd0);
    step();
    check("r0_bypass", {16'b0, bus.rdata[15:0]}, {16'b0, R0_EXP});
    idle();
    step();

    // Randomized traffic with occasional flush and clear.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      clear = (r < 3);
      drive(r >= 3 && r < 15, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
    end
    clear = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) step();

    check("queue_drain", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
